// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT frame sequencer: controller states,
// default FFT configuration word and the ADC-to-FFT sample conversion.
package fft_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_FILL,
    ST_WAIT_OUT,
    ST_WAIT_ANA,
    ST_UPDATE,
    ST_GAP
  } state_t;

  localparam logic [15:0] CFG_WORD_DEFAULT = 16'h0001;
  localparam int ADC_W  = 12;
  localparam int FFT_DW = 16;

  // Offset binary to two's complement: flipping the MSB subtracts mid-scale.
  function automatic logic [FFT_DW-1:0] adc_to_signed(input logic [ADC_W-1:0] sample);
    return {{(FFT_DW-ADC_W){~sample[ADC_W-1]}}, ~sample[ADC_W-1], sample[ADC_W-2:0]};
  endfunction

endpackage

// File: rtl/adc_skid_reg.sv
// One-entry AXI-Stream holding register between the ADC strobe and the FFT
// input; reports a drop when a sample arrives while the entry is stuck full.
module adc_skid_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         drop
);

  logic         full_reg;
  logic [W-1:0] data_reg;
  logic         drain;
  logic         capture;

  assign drain   = full_reg && out_ready;
  // The cycle that closes a frame never refills, so nothing leaks into the next frame.
  assign capture = enable && in_valid && !flush && (!full_reg || drain);
  assign drop    = enable && in_valid && full_reg && !drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg <= 1'b0;
    end else if (capture) begin
      full_reg <= 1'b1;
    end else if (drain || flush) begin
      full_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      data_reg <= in_data;
    end
  end

  assign out_valid = full_reg;
  assign out_data  = data_reg;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame-level controller: one-time FFT configuration, FFT_LEN-point frame packing,
// wait for FFT output and classifier, peak-tracker update pulse, stall watchdog.
module fft_frame_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int          FFT_LEN    = 1024,
  parameter logic [15:0] CFG_WORD   = CFG_WORD_DEFAULT,
  parameter int          GAP_CYCLES = 16,
  parameter int          TIMEOUT    = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        adc_valid,
  input  logic [11:0] adc_data,
  output logic [15:0] cfg_tdata,
  output logic        cfg_tvalid,
  input  logic        cfg_tready,
  output logic [31:0] s_tdata,
  output logic        s_tvalid,
  output logic        s_tlast,
  input  logic        s_tready,
  input  logic        fft_out_last,
  input  logic        fft_out_valid,
  input  logic        ana_done,
  output logic        update,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        overrun,
  output logic        timeout
);

  localparam int IDX_W = $clog2(FFT_LEN);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  state_t             state_reg, state_next;
  logic               cfg_sent_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               last_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;
  logic [WD_W-1:0]    wd_cnt_reg;
  logic               ana_prev_reg;
  logic [15:0]        frame_cnt_reg;
  logic               overrun_reg;
  logic               timeout_reg;
  logic               wd_forced_reg;
  logic               cfg_tvalid_reg;
  logic               update_reg;
  logic               busy_reg;

  logic               in_fill;
  logic               beat;
  logic               last_beat;
  logic               ana_edge;
  logic               waiting;
  logic               wd_expire;
  logic               wd_fire;
  logic               gap_done;
  logic               skid_valid;
  logic [FFT_DW-1:0]  skid_data;
  logic               skid_drop;

  assign in_fill   = (state_reg == ST_FILL);
  assign beat      = in_fill && skid_valid && s_tready;
  assign last_beat = beat && last_reg;
  assign ana_edge  = ana_done && !ana_prev_reg;
  assign waiting   = (state_reg == ST_WAIT_OUT) || (state_reg == ST_WAIT_ANA);
  assign wd_expire = waiting && (wd_cnt_reg == WD_W'(TIMEOUT - 1));
  assign gap_done  = (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1));

  adc_skid_reg #(.W(FFT_DW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .enable    (in_fill),
    .flush     (last_beat),
    .in_valid  (adc_valid),
    .in_data   (adc_to_signed(adc_data)),
    .out_ready (s_tready),
    .out_valid (skid_valid),
    .out_data  (skid_data),
    .drop      (skid_drop)
  );

  always_comb begin
    state_next = state_reg;
    wd_fire    = 1'b0;
    case (state_reg)
      ST_IDLE:     if (run) state_next = cfg_sent_reg ? ST_FILL : ST_CONFIG;
      ST_CONFIG:   if (cfg_tvalid_reg && cfg_tready) state_next = ST_FILL;
      ST_FILL:     if (last_beat) state_next = ST_WAIT_OUT;
      ST_WAIT_OUT: begin
        // A genuine completion in the expiry cycle takes precedence over the watchdog.
        if (fft_out_valid && fft_out_last) begin
          state_next = ST_WAIT_ANA;
        end else if (wd_expire) begin
          state_next = ST_UPDATE;
          wd_fire    = 1'b1;
        end
      end
      ST_WAIT_ANA: begin
        if (ana_edge) begin
          state_next = ST_UPDATE;
        end else if (wd_expire) begin
          state_next = ST_UPDATE;
          wd_fire    = 1'b1;
        end
      end
      ST_UPDATE:   state_next = ST_GAP;
      ST_GAP:      if (gap_done) state_next = run ? ST_FILL : ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cfg_sent_reg   <= 1'b0;
      idx_reg        <= '0;
      last_reg       <= 1'b0;
      gap_cnt_reg    <= '0;
      wd_cnt_reg     <= '0;
      ana_prev_reg   <= 1'b0;
      frame_cnt_reg  <= 16'h0000;
      overrun_reg    <= 1'b0;
      timeout_reg    <= 1'b0;
      wd_forced_reg  <= 1'b0;
      cfg_tvalid_reg <= 1'b0;
      update_reg     <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cfg_tvalid_reg <= (state_next == ST_CONFIG);
      update_reg     <= (state_next == ST_UPDATE);
      busy_reg       <= (state_next != ST_IDLE);

      if (state_reg == ST_CONFIG && cfg_tvalid_reg && cfg_tready) cfg_sent_reg <= 1'b1;

      if (state_next == ST_FILL && state_reg != ST_FILL) begin
        idx_reg  <= '0;
        last_reg <= 1'b0;
      end else if (beat) begin
        idx_reg  <= idx_reg + IDX_W'(1);
        last_reg <= (idx_reg == IDX_W'(FFT_LEN - 2));
      end

      gap_cnt_reg <= (state_reg == ST_GAP) ? gap_cnt_reg + GAP_W'(1) : '0;

      if (!waiting || state_next != state_reg) wd_cnt_reg <= '0;
      else                                     wd_cnt_reg <= wd_cnt_reg + WD_W'(1);

      // Clearing on entry makes a level that is already high count as an edge.
      if (state_next == ST_WAIT_ANA && state_reg != ST_WAIT_ANA) ana_prev_reg <= 1'b0;
      else                                                       ana_prev_reg <= ana_done;

      if (state_next == ST_UPDATE) wd_forced_reg <= wd_fire;
      if (state_reg == ST_UPDATE && !wd_forced_reg) frame_cnt_reg <= frame_cnt_reg + 16'd1;

      if (wd_fire)   timeout_reg <= 1'b1;
      if (skid_drop) overrun_reg <= 1'b1;
    end
  end

  assign cfg_tdata  = CFG_WORD;
  assign cfg_tvalid = cfg_tvalid_reg;
  assign s_tdata    = {16'h0000, skid_data};
  assign s_tvalid   = skid_valid;
  assign s_tlast    = last_reg;
  assign update     = update_reg;
  assign busy       = busy_reg;
  assign frame_cnt  = frame_cnt_reg;
  assign overrun    = overrun_reg;
  assign timeout    = timeout_reg;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer: a one-slot buffer model predicts
// delivered samples; a negedge monitor pops and compares every FFT input beat.
module tb_fft_frame_sequencer;

  localparam int FFT_LEN = 8;
  localparam int GAP     = 16;
  localparam int TMO     = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        adc_valid = 1'b0;
  logic [11:0] adc_data = 12'd0;
  logic        cfg_tready = 1'b0;
  logic        s_tready = 1'b0;
  logic        fft_out_last = 1'b0;
  logic        fft_out_valid = 1'b0;
  logic        ana_done = 1'b0;
  logic [15:0] cfg_tdata;
  logic        cfg_tvalid;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        update;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        overrun;
  logic        timeout;

  fft_frame_sequencer #(
    .FFT_LEN(FFT_LEN), .CFG_WORD(16'h0001), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .adc_valid(adc_valid), .adc_data(adc_data),
    .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .fft_out_last(fft_out_last), .fft_out_valid(fft_out_valid), .ana_done(ana_done),
    .update(update), .busy(busy), .frame_cnt(frame_cnt), .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    bit          last;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cfg_beats = 0;
  bit          in_fill = 0;
  bit          frame_done = 0;
  bit          exp_overrun = 0;
  int          cd = 0;
  int          occ = 0;
  int          pushed = 0;
  int          beats = 0;
  int          mode = 0;
  int          cyc = 0;
  logic [11:0] tbl [8];

  function automatic logic [15:0] conv(input logic [11:0] a);
    int v;
    v = int'(a) - 2048;
    return v[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Reference model of the frame: samples offered in FILL land in a single slot,
  // which empties when the consumer is ready; the frame closes after FFT_LEN deliveries.
  task automatic model_edge();
    beat_t b;
    bit    drained;
    if (in_fill) begin
      drained = (occ != 0) && s_tready;
      if (drained) begin
        occ = 0;
        beats++;
        if (beats == FFT_LEN) begin
          in_fill    = 0;
          frame_done = 1;
        end
      end
      if (in_fill && adc_valid) begin
        if (occ == 0) begin
          b.d    = conv(adc_data);
          b.last = (pushed == FFT_LEN - 1);
          exp_q.push_back(b);
          pushed++;
          occ = 1;
        end else begin
          exp_overrun = 1;
        end
      end
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        in_fill = 1;
        occ     = 0;
        pushed  = 0;
        beats   = 0;
      end
    end
  endtask

  task automatic run_cycle();
    case (mode)
      0: begin adc_valid = 1'b1; adc_data = tbl[pushed % 8]; s_tready = 1'b1; end
      1: begin adc_valid = 1'b1; adc_data = 12'($urandom); s_tready = ((cyc % 2) == 0); end
      2: begin
        adc_valid = 1'($urandom_range(0, 1));
        adc_data  = 12'($urandom);
        s_tready  = ($urandom_range(0, 3) != 0);
      end
      default: begin adc_valid = 1'b0; s_tready = 1'b1; end
    endcase
    cyc++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wait_frame(input int bound);
    int n = 0;
    while (!frame_done && n < bound) begin
      run_cycle();
      n++;
    end
    if (!frame_done) begin
      checks++;
      errors++;
      $display("FAIL frame_wait: frame not completed within %0d cycles", bound);
      finish_sim();
    end
    frame_done = 0;
  endtask

  // Monitor: every presented beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (cfg_tvalid && cfg_tready) begin
        cfg_beats++;
        chk("cfg_tdata", {16'h0, cfg_tdata}, 32'h0001);
      end
      if (s_tvalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {31'h0, s_tvalid}, 32'h0);
        end else begin
          chk("s_tdata", s_tdata, {16'h0, exp_q[0].d});
          chk("s_tlast", {31'h0, s_tlast}, {31'h0, exp_q[0].last});
          if (s_tready) void'(exp_q.pop_front());
        end
      end
      chk("overrun", {31'h0, overrun}, {31'h0, exp_overrun});
    end
  end

  initial begin
    int n;
    tbl = '{12'd0, 12'd2048, 12'd4095, 12'd1, 12'd2047, 12'd3000, 12'd100, 12'd4000};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_cfg_tvalid", {31'h0, cfg_tvalid}, 32'h0);
    chk("rst_s_tvalid", {31'h0, s_tvalid}, 32'h0);
    chk("rst_update", {31'h0, update}, 32'h0);
    chk("rst_frame_cnt", {16'h0, frame_cnt}, 32'h0);
    chk("rst_timeout", {31'h0, timeout}, 32'h0);

    // Frame 1: configuration handshake delayed 3 cycles, continuous samples.
    rst  = 1'b0;
    mode = 0;
    run  = 1'b1;
    run_cycle();
    chk("cfg_tvalid_up", {31'h0, cfg_tvalid}, 32'h1);
    chk("busy_up", {31'h0, busy}, 32'h1);
    repeat (3) begin
      run_cycle();
      chk("cfg_tvalid_held", {31'h0, cfg_tvalid}, 32'h1);
    end
    cfg_tready = 1'b1;
    cd = 1;
    run_cycle();
    chk("cfg_tvalid_down", {31'h0, cfg_tvalid}, 32'h0);
    chk("cfg_beats_1", cfg_beats, 1);
    wait_frame(100);
    chk("busy_wait_out", {31'h0, busy}, 32'h1);
    repeat (4) run_cycle();
    fft_out_valid = 1'b1;
    run_cycle();
    fft_out_valid = 1'b0;
    ana_done = 1'b1;
    run_cycle();
    ana_done = 1'b0;
    repeat (2) run_cycle();
    chk("no_update_wait_out", {31'h0, update}, 32'h0);
    fft_out_valid = 1'b1;
    fft_out_last  = 1'b1;
    run_cycle();
    fft_out_valid = 1'b0;
    fft_out_last  = 1'b0;
    repeat (20) run_cycle();
    chk("no_update_wait_ana", {31'h0, update}, 32'h0);
    ana_done = 1'b1;
    run_cycle();
    chk("update_pulse", {31'h0, update}, 32'h1);
    chk("frame_cnt_pre", {16'h0, frame_cnt}, 32'h0);
    cd   = GAP + 1;
    mode = 1;
    run_cycle();
    ana_done = 1'b0;
    chk("update_one_cycle", {31'h0, update}, 32'h0);
    chk("frame_cnt_1", {16'h0, frame_cnt}, 32'h1);

    // Frame 2: ready toggling forces drops; FFT never answers, watchdog recovers.
    wait_frame(300);
    chk("overrun_sticky", {31'h0, overrun}, 32'h1);
    repeat (TMO - 1) run_cycle();
    chk("timeout_before", {31'h0, timeout}, 32'h0);
    chk("update_before_tmo", {31'h0, update}, 32'h0);
    run_cycle();
    chk("timeout_set", {31'h0, timeout}, 32'h1);
    chk("update_tmo", {31'h0, update}, 32'h1);
    cd   = GAP + 1;
    mode = 2;
    run_cycle();
    chk("update_tmo_end", {31'h0, update}, 32'h0);
    chk("frame_cnt_tmo", {16'h0, frame_cnt}, 32'h1);

    // Frame 3: random traffic, run dropped mid-frame, ana_done already high.
    n = 0;
    while (!(in_fill && pushed >= 3) && n < 100) begin
      run_cycle();
      n++;
    end
    run = 1'b0;
    wait_frame(300);
    ana_done = 1'b1;
    repeat (3) run_cycle();
    fft_out_valid = 1'b1;
    fft_out_last  = 1'b1;
    run_cycle();
    fft_out_valid = 1'b0;
    fft_out_last  = 1'b0;
    chk("update_not_yet", {31'h0, update}, 32'h0);
    run_cycle();
    chk("update_level_entry", {31'h0, update}, 32'h1);
    run_cycle();
    ana_done = 1'b0;
    chk("frame_cnt_2", {16'h0, frame_cnt}, 32'h2);
    repeat (GAP - 1) run_cycle();
    chk("busy_in_gap", {31'h0, busy}, 32'h1);
    run_cycle();
    chk("busy_idle", {31'h0, busy}, 32'h0);
    repeat (5) run_cycle();
    chk("busy_stays_idle", {31'h0, busy}, 32'h0);
    chk("cfg_beats_once", cfg_beats, 1);

    // Frame 4: straight to FILL without config, then reset mid-frame.
    run = 1'b1;
    cd  = 1;
    run_cycle();
    chk("busy_refill", {31'h0, busy}, 32'h1);
    chk("no_second_cfg", {31'h0, cfg_tvalid}, 32'h0);
    repeat (4) run_cycle();
    rst = 1'b1;
    exp_q.delete();
    in_fill     = 0;
    cd          = 0;
    occ         = 0;
    exp_overrun = 0;
    run_cycle();
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_s_tvalid", {31'h0, s_tvalid}, 32'h0);
    chk("midrst_frame_cnt", {16'h0, frame_cnt}, 32'h0);
    chk("midrst_overrun", {31'h0, overrun}, 32'h0);
    chk("midrst_timeout", {31'h0, timeout}, 32'h0);
    rst  = 1'b0;
    mode = 3;
    n = 0;
    while (cfg_beats < 2 && n < 10) begin
      run_cycle();
      n++;
    end
    chk("cfg_resent", cfg_beats, 2);
    finish_sim();
  end

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Frame-level controller for the spectrum-analysis chain. It configures the FFT core once after reset and packs ADC samples into exactly FFT_LEN-point input frames. It then waits for the FFT output frame and the downstream magnitude/peak classifier to finish, and issues the `update` pulse that clears the peak trackers before the next frame. A watchdog recovers the chain if the FFT or classifier stalls.

## Interface
- FFT_LEN, 1024, points per frame; power of two, 8..4096
- CFG_WORD, 16'h0001, FFT config word (bit0 = forward transform)
- GAP_CYCLES, 16, idle cycles between `update` and the next frame fill
- TIMEOUT, 65535, watchdog limit in cycles for the WAIT_OUT and WAIT_ANA states
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- run  in  1  level; 1 = acquire frames continuously
- adc_valid  in  1  ADC sample strobe
- adc_data  in  12  ADC sample, offset binary
- cfg_tdata  out  16  FFT config stream data (= CFG_WORD)
- cfg_tvalid  out  1  FFT config valid
- cfg_tready  in  1  FFT config ready
- s_tdata  out  32  FFT input: [31:16] im = 0, [15:0] re, signed
- s_tvalid  out  1  FFT input valid
- s_tlast  out  1  last sample of frame
- s_tready  in  1  FFT input ready
- fft_out_last  in  1  FFT output tlast (qualified by the FFT output tvalid)
- fft_out_valid  in  1  FFT output tvalid
- ana_done  in  1  classifier finished (level or pulse; rising edge used)
- update  out  1  one-cycle pulse that clears downstream peak trackers
- busy  out  1  state != IDLE
- frame_cnt  out  16  completed frames, wraps at 16'hFFFF -> 0
- overrun  out  1  sticky: a sample was dropped in FILL
- timeout  out  1  sticky: watchdog expired

## Operation
- States: IDLE, CONFIG, FILL, WAIT_OUT, WAIT_ANA, UPDATE, GAP.
- Transitions:
  - IDLE -> CONFIG when `run` = 1 and the config has not been sent since reset.
  - IDLE -> FILL when `run` = 1 and the config has already been sent.
  - CONFIG -> FILL on `cfg_tvalid && cfg_tready`; this also sets the internal cfg_sent flag.
  - FILL -> WAIT_OUT on the accepted beat that has `s_tlast` = 1.
  - WAIT_OUT -> WAIT_ANA on `fft_out_valid && fft_out_last`.
  - WAIT_ANA -> UPDATE on a rising edge of `ana_done`.
  - UPDATE -> GAP after exactly 1 cycle.
  - GAP -> FILL after GAP_CYCLES cycles if `run` = 1; otherwise GAP -> IDLE.
- Sample conversion: `s_tdata[15:0]` = sign-extend({~adc_data[11], adc_data[10:0]}), i.e. adc_data - 2048. `s_tdata[31:16]` = 0.
- Input skid register: one entry.
  - Captures a sample on `adc_valid` when it is empty, or when it is being drained in the same cycle.
  - `s_tvalid` = entry full, and only in FILL.
  - When `adc_valid` arrives with the entry full and not draining, the sample is dropped and `overrun` is set.
- Sample index counter: counts accepted beats, 0..FFT_LEN-1. `s_tlast` = (index == FFT_LEN-1). Cleared on entering FILL.
- `frame_cnt` increments in UPDATE.
- `run` deasserted mid-frame does not abort; the current frame completes through GAP, then the block goes to IDLE.
- Watchdog:
  - Counts cycles spent in WAIT_OUT or WAIT_ANA and resets on every state change.
  - On reaching TIMEOUT it sets `timeout` and forces UPDATE, so the peak trackers are cleared and the chain re-arms. `frame_cnt` is not incremented in this case.
- `adc_valid` outside FILL is ignored; it does not set `overrun`.

## Timing
- Reset values: cfg_tvalid = 0, s_tvalid = 0, s_tlast = 0, update = 0, busy = 0, frame_cnt = 0, overrun = 0, timeout = 0, cfg_sent = 0, state = IDLE.
- All outputs are registered.
- `s_tvalid`/`s_tdata` follow `adc_valid` by 1 cycle. Holding `s_tready` = 1 gives 1 sample/cycle throughput.
- AXI-S rule: once `s_tvalid` is asserted, `s_tdata`/`s_tlast` stay stable until `s_tready`.
- `cfg_tvalid` is held until accepted.
- `update` asserts 1 cycle after the `ana_done` edge is detected.
- `ana_done` rising while in WAIT_OUT is ignored: the edge detector is reset on entry to WAIT_ANA. A level that is already high on entry counts as an edge.
- Reset mid-frame: returns to IDLE next cycle, the config is re-sent, and the partial frame is discarded.

## Structure
- Package `fft_ctrl_pkg`:
  - state enum.
  - CFG_WORD default.
  - ADC_W = 12, FFT_DW = 16.
- Sub-module `adc_skid_reg`: one-entry AXI-S skid register with drop/overrun flag.
- The FSM, counters and watchdog stay in the top level.

## Test plan
- Reset then `run` = 1, `cfg_tready` = 1 after 3 cycles → one config beat 16'h0001; FILL entered; no second config on later frames.
- FFT_LEN = 8, adc_data 0, 2048, 4095 continuous, `s_tready` = 1 → re = -2048, 0, 2047; `s_tlast` on the 8th beat; then WAIT_OUT.
- `s_tready` toggling 1/0 with continuous `adc_valid` → data stable while stalled, `overrun` = 1, exactly 8 beats delivered.
- `fft_out_last` then `ana_done` after 20 cycles → `update` pulse of 1 cycle, `frame_cnt` = 1, GAP lasts 16 cycles before the next FILL.
- TIMEOUT = 100, no `fft_out_last` → `timeout` = 1 at cycle 100 of WAIT_OUT, `update` pulses, `frame_cnt` unchanged.
- `run` dropped mid-FILL → frame completes, UPDATE, GAP, IDLE; `busy` = 0.
